// File: rtl/sdram_burst_scheduler_pkg.sv
// sdram_sched_pkg: shared types and constants for the SDRAM burst scheduler.
//   sched_cmd_t       controller command / scheduler state encoding
//   SDRAM_ADDR_WIDTH  word address width of the as4c4m16sa controller
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    CMD_IDLE  = 2'd0,
    CMD_WRITE = 2'd1,
    CMD_READ  = 2'd2
  } sched_cmd_t;

  localparam int SDRAM_ADDR_WIDTH = 22;

endpackage

// File: rtl/sdram_burst_scheduler_if.sv
// sdram_burst_scheduler_if: scheduler <-> SDRAM controller bus.
//   command          0 idle, 1 write, 2 read (scheduler -> controller)
//   data_address     burst word address (scheduler -> controller)
//   data_write_done  one write beat accepted (controller -> scheduler)
//   data_read_valid  one read beat presented (controller -> scheduler)
// Modports: master = scheduler side, slave = controller side.
interface sdram_burst_scheduler_if;
  import sdram_sched_pkg::*;

  logic [1:0]                  command;
  logic [SDRAM_ADDR_WIDTH-1:0] data_address;
  logic                        data_write_done;
  logic                        data_read_valid;

  modport master (
    output command, data_address,
    input  data_write_done, data_read_valid
  );

  modport slave (
    input  command, data_address,
    output data_write_done, data_read_valid
  );

endinterface

// File: rtl/sdram_burst_scheduler_addr_cnt.sv
// burst_address_counter: ring-buffer burst address register.
//   sdram_clk, sdram_rst_n  clock, async active-low reset
//   advance                 step by BURST_LENGTH, wrapping to 0 at VIDEO_END
//   clear                   force address to 0 (wins over advance)
//   addr                    current burst word address
module burst_address_counter
  import sdram_sched_pkg::*;
#(
  parameter int BURST_LENGTH = 8,
  parameter int VIDEO_END    = 153600
) (
  input  logic                        sdram_clk,
  input  logic                        sdram_rst_n,
  input  logic                        advance,
  input  logic                        clear,
  output logic [SDRAM_ADDR_WIDTH-1:0] addr
);

  localparam logic [SDRAM_ADDR_WIDTH-1:0] STEP    = SDRAM_ADDR_WIDTH'(BURST_LENGTH);
  localparam logic [SDRAM_ADDR_WIDTH-1:0] WRAP_AT = SDRAM_ADDR_WIDTH'(VIDEO_END);

  logic [SDRAM_ADDR_WIDTH-1:0] addr_sum;

  assign addr_sum = addr + STEP;

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      addr <= '0;
    end else if (clear) begin
      addr <= '0;
    end else if (advance) begin
      addr <= (addr_sum == WRAP_AT) ? '0 : addr_sum;
    end
  end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// sdram_burst_scheduler: arbitrates 8-beat SDRAM bursts between the camera
// write FIFO and the pixel read FIFO, with bounded write priority, frame
// restart of the write address and ring wrap at VIDEO_END.
//   sdram_clk, sdram_rst_n  clock, async active-low reset
//   wr_level / wr_ack       write FIFO fill level / pop strobe
//   rd_level / rd_push      read FIFO fill level / push strobe
//   frame_restart           synchronised pulse, restarts the write address
//   busy                    high during a WRITE or READ burst
//   bus                     controller bus (command, address, beat strobes)
// Optional: SDRAM_SCHED_STATS_EN adds stat_wr_bursts, stat_rd_bursts and
// stat_starve_events (16-bit wrapping counters).
//
// state      | meaning
// CMD_IDLE   | no burst; arbitration decision every cycle
// CMD_WRITE  | write burst, one wr_ack per accepted beat
// CMD_READ   | read burst, one rd_push per returned beat
module sdram_burst_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int BURST_LENGTH     = 8,
  parameter int VIDEO_END        = 153600,
  parameter int WR_LEVEL_WIDTH   = 8,
  parameter int RD_LEVEL_WIDTH   = 8,
  parameter int MAX_WRITE_STREAK = 4
) (
  input  logic                      sdram_clk,
  input  logic                      sdram_rst_n,
  input  logic [WR_LEVEL_WIDTH-1:0] wr_level,
  output logic                      wr_ack,
  input  logic [RD_LEVEL_WIDTH-1:0] rd_level,
  output logic                      rd_push,
  input  logic                      frame_restart,
  output logic                      busy,
  sdram_burst_scheduler_if.master   bus
`ifdef SDRAM_SCHED_STATS_EN
  ,
  output logic [15:0]               stat_wr_bursts,
  output logic [15:0]               stat_rd_bursts,
  output logic [15:0]               stat_starve_events
`endif
);

  localparam int BEAT_W   = $clog2(BURST_LENGTH);
  localparam int STREAK_W = $clog2(MAX_WRITE_STREAK + 1);

  localparam logic [BEAT_W-1:0]         LAST_BEAT  = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [STREAK_W-1:0]       STREAK_MAX = STREAK_W'(MAX_WRITE_STREAK);
  localparam logic [WR_LEVEL_WIDTH:0]   WR_MIN     = (WR_LEVEL_WIDTH + 1)'(BURST_LENGTH);
  // Room for a whole burst must remain in the read FIFO.
  localparam logic [RD_LEVEL_WIDTH:0]   RD_MAX     =
    (RD_LEVEL_WIDTH + 1)'((1 << RD_LEVEL_WIDTH) - 1 - BURST_LENGTH);

  sched_cmd_t                  state;
  logic [BEAT_W-1:0]           beat_cnt;
  logic [STREAK_W-1:0]         streak;
  logic                        restart_pending;
  logic [SDRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [SDRAM_ADDR_WIDTH-1:0] rd_addr;

  logic write_ok, read_ok, streak_full, restart_req;
  logic wr_last, rd_last, go_read;
  logic wr_addr_clear, wr_addr_adv;

  assign write_ok    = {1'b0, wr_level} >= WR_MIN;
  assign read_ok     = {1'b0, rd_level} <= RD_MAX;
  assign streak_full = streak >= STREAK_MAX;
  assign restart_req = restart_pending | frame_restart;

  assign wr_ack  = (state == CMD_WRITE) && bus.data_write_done;
  assign rd_push = (state == CMD_READ) && bus.data_read_valid;
  assign wr_last = wr_ack && (beat_cnt == LAST_BEAT);
  assign rd_last = rd_push && (beat_cnt == LAST_BEAT);
  assign go_read = (state == CMD_IDLE) && read_ok && (streak_full || !write_ok);

  // A pending restart is applied at the next point the write address is
  // free to move: while idle, or at the end of the running write burst.
  assign wr_addr_clear = restart_req && ((state == CMD_IDLE) || wr_last);
  assign wr_addr_adv   = wr_last && !restart_req;

  assign bus.command      = state;
  assign bus.data_address = (state == CMD_WRITE) ? wr_addr :
                            (state == CMD_READ)  ? rd_addr : '0;
  assign busy             = (state != CMD_IDLE);

  burst_address_counter #(
    .BURST_LENGTH (BURST_LENGTH),
    .VIDEO_END    (VIDEO_END)
  ) u_wr_addr (
    .sdram_clk   (sdram_clk),
    .sdram_rst_n (sdram_rst_n),
    .advance     (wr_addr_adv),
    .clear       (wr_addr_clear),
    .addr        (wr_addr)
  );

  burst_address_counter #(
    .BURST_LENGTH (BURST_LENGTH),
    .VIDEO_END    (VIDEO_END)
  ) u_rd_addr (
    .sdram_clk   (sdram_clk),
    .sdram_rst_n (sdram_rst_n),
    .advance     (rd_last),
    .clear       (1'b0),
    .addr        (rd_addr)
  );

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      state    <= CMD_IDLE;
      beat_cnt <= '0;
      streak   <= '0;
    end else begin
      case (state)
        CMD_IDLE: begin
          beat_cnt <= '0;
          if (go_read) begin
            state <= CMD_READ;
          end else if (write_ok) begin
            state <= CMD_WRITE;
          end
        end
        CMD_WRITE: begin
          if (wr_ack) begin
            if (wr_last) begin
              state    <= CMD_IDLE;
              beat_cnt <= '0;
              if (!streak_full) streak <= streak + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        CMD_READ: begin
          if (rd_push) begin
            if (rd_last) begin
              state    <= CMD_IDLE;
              beat_cnt <= '0;
              streak   <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= CMD_IDLE;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      restart_pending <= 1'b0;
    end else if (wr_addr_clear) begin
      restart_pending <= 1'b0;
    end else if (frame_restart) begin
      restart_pending <= 1'b1;
    end
  end

`ifdef SDRAM_SCHED_STATS_EN
  always_ff @(posedge sdram_clk or negedge sdram_rst_n) begin
    if (!sdram_rst_n) begin
      stat_wr_bursts     <= '0;
      stat_rd_bursts     <= '0;
      stat_starve_events <= '0;
    end else begin
      if (wr_last) stat_wr_bursts <= stat_wr_bursts + 16'd1;
      if (rd_last) stat_rd_bursts <= stat_rd_bursts + 16'd1;
      // Starvation guard fired: a write was eligible but the streak forced a read.
      if (go_read && streak_full && write_ok) stat_starve_events <= stat_starve_events + 16'd1;
    end
  end
`else
  // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_sdram_burst_scheduler.sv
// Directed bench for sdram_burst_scheduler. VIDEO_END is reduced to 128 so
// the ring wrap is reached within a short run.
module tb_sdram_burst_scheduler;
  import sdram_sched_pkg::*;

  localparam int BL   = 8;
  localparam int VEND = 128;

  logic       sdram_clk = 1'b0;
  logic       sdram_rst_n;
  logic [7:0] wr_level;
  logic [7:0] rd_level;
  logic       wr_ack;
  logic       rd_push;
  logic       frame_restart;
  logic       busy;
`ifdef SDRAM_SCHED_STATS_EN
  logic [15:0] stat_wr_bursts, stat_rd_bursts, stat_starve_events;
`endif

  sdram_burst_scheduler_if bus ();

  sdram_burst_scheduler #(
    .BURST_LENGTH     (BL),
    .VIDEO_END        (VEND),
    .WR_LEVEL_WIDTH   (8),
    .RD_LEVEL_WIDTH   (8),
    .MAX_WRITE_STREAK (4)
  ) dut (
    .sdram_clk     (sdram_clk),
    .sdram_rst_n   (sdram_rst_n),
    .wr_level      (wr_level),
    .wr_ack        (wr_ack),
    .rd_level      (rd_level),
    .rd_push       (rd_push),
    .frame_restart (frame_restart),
    .busy          (busy),
    .bus           (bus)
`ifdef SDRAM_SCHED_STATS_EN
    ,
    .stat_wr_bursts     (stat_wr_bursts),
    .stat_rd_bursts     (stat_rd_bursts),
    .stat_starve_events (stat_starve_events)
`endif
  );

  always #5 sdram_clk = ~sdram_clk;

  int tests = 0;
  int fails = 0;

  // Burst log gathered on the falling edge.
  logic [1:0]  q_cmd[$];
  logic [21:0] q_addr[$];
  int          q_beats[$];
  int          q_gap[$];
  int          stray = 0, addr_bad = 0, busy_bad = 0, trans_bad = 0;
  logic [1:0]  prev_cmd = 2'd0;
  logic [21:0] cur_addr = '0;
  int          beats = 0;
  int          idle_cnt = 100;

  always @(negedge sdram_clk) begin
    if (busy !== (bus.command != 2'd0)) busy_bad++;
    if (wr_ack && bus.command != 2'd1) stray++;
    if (rd_push && bus.command != 2'd2) stray++;
    if (bus.command != 2'd0) begin
      if (prev_cmd == 2'd0) begin
        q_cmd.push_back(bus.command);
        q_addr.push_back(bus.data_address);
        q_gap.push_back(idle_cnt);
        cur_addr = bus.data_address;
        beats = 0;
      end else if (bus.command != prev_cmd) begin
        trans_bad++;
      end
      if (bus.data_address != cur_addr) addr_bad++;
      if ((bus.command == 2'd1 && wr_ack) || (bus.command == 2'd2 && rd_push)) beats++;
      idle_cnt = 0;
    end else begin
      if (prev_cmd != 2'd0) q_beats.push_back(beats);
      idle_cnt++;
    end
    prev_cmd = bus.command;
  end

  logic [21:0] m_wr = '0;
  logic [21:0] m_rd = '0;
  logic [21:0] rd_before;

  function automatic logic [21:0] adv(input logic [21:0] a);
    return (a + 22'(BL) == 22'(VEND)) ? 22'd0 : a + 22'(BL);
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sdram_clk);
    #1;
  endtask

  task automatic clear_log();
    q_cmd.delete();
    q_addr.delete();
    q_beats.delete();
    q_gap.delete();
  endtask

  task automatic wait_cmd(input logic [1:0] c, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      tick();
      if (bus.command == c) hit = 1'b1;
    end
    chk(tag, longint'(hit), 1);
  endtask

  task automatic wait_bursts(input int n, input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      tick();
      if (q_beats.size() >= n) hit = 1'b1;
    end
    chk(tag, longint'(hit), 1);
  endtask

  task automatic one_write();
    wr_level = 8'd8;
    wait_cmd(2'd1, "wr_start");
    wr_level = 8'd0;
    wait_cmd(2'd0, "wr_end");
    tick();
  endtask

  task automatic one_read();
    rd_level = 8'd0;
    wait_cmd(2'd2, "rd_start");
    rd_level = 8'd255;
    wait_cmd(2'd0, "rd_end");
    tick();
  endtask

  // Scores every logged burst against the address model.
  task automatic check_log(input string tag);
    chk({tag, "_complete"}, q_beats.size(), q_cmd.size());
    foreach (q_beats[i]) begin
      chk($sformatf("%s_beats[%0d]", tag, i), q_beats[i], BL);
      chk($sformatf("%s_gap[%0d]", tag, i), longint'(q_gap[i] >= 1), 1);
      if (q_cmd[i] == 2'd1) begin
        chk($sformatf("%s_wr_addr[%0d]", tag, i), q_addr[i], m_wr);
        m_wr = adv(m_wr);
      end else begin
        chk($sformatf("%s_rd_addr[%0d]", tag, i), q_addr[i], m_rd);
        m_rd = adv(m_rd);
      end
    end
    clear_log();
  endtask

  initial begin
    sdram_rst_n          = 1'b1;
    wr_level             = 8'd0;
    rd_level             = 8'd255;
    frame_restart        = 1'b0;
    bus.data_write_done  = 1'b1;
    bus.data_read_valid  = 1'b1;
    #2 sdram_rst_n = 1'b0;
    repeat (3) tick();

    // Reset state with both controller strobes asserted.
    chk("rst_command", bus.command, 0);
    chk("rst_address", bus.data_address, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wr_ack", wr_ack, 0);
    chk("rst_rd_push", rd_push, 0);
    sdram_rst_n = 1'b1;
    repeat (2) tick();

    // One short of eligibility on both sides: stays idle.
    wr_level = 8'd7;
    rd_level = 8'd248;
    repeat (4) tick();
    chk("inelig_command", bus.command, 0);
    chk("inelig_bursts", q_cmd.size(), 0);

    // Back-to-back writes at the wr_level boundary.
    wr_level = 8'd8;
    rd_level = 8'd255;
    wait_bursts(2, "wr_pair_timeout");
    wr_level = 8'd0;
    wait_cmd(2'd0, "wr_pair_idle");
    tick();
    chk("wr_pair_cmd0", q_cmd[0], 1);
    chk("wr_pair_addr0", q_addr[0], 0);
    chk("wr_pair_addr1", q_addr[1], 8);
    chk("wr_pair_beats0", q_beats[0], 8);
    chk("wr_pair_gap1", q_gap[1], 1);
    check_log("wr_pair");

    // Reads only, rd_level at its eligibility boundary.
    rd_level = 8'd247;
    wait_bursts(3, "rd_run_timeout");
    rd_level = 8'd255;
    wait_cmd(2'd0, "rd_run_idle");
    tick();
    chk("rd_run_cmd0", q_cmd[0], 2);
    chk("rd_run_cmd2", q_cmd[2], 2);
    chk("rd_run_addr0", q_addr[0], 0);
    chk("rd_run_addr1", q_addr[1], 8);
    chk("rd_run_addr2", q_addr[2], 16);
    check_log("rd_run");

    // Both eligible: four writes, then a forced read, repeating.
    wr_level = 8'd200;
    rd_level = 8'd0;
    wait_bursts(10, "streak_timeout");
    wr_level = 8'd0;
    rd_level = 8'd255;
    wait_cmd(2'd0, "streak_idle");
    tick();
    for (int i = 0; i < 10; i++)
      chk($sformatf("streak_cmd[%0d]", i), q_cmd[i], (i == 4 || i == 9) ? 2 : 1);
    check_log("streak");

    // Walk the write address up to the last slot, then wrap.
    for (int k = 0; k < 20 && m_wr != 22'(VEND - BL); k++) begin
      one_write();
      check_log("wrap_pre");
    end
    one_write();
    one_write();
    chk("wrap_last_addr", q_addr[0], VEND - BL);
    chk("wrap_first_addr", q_addr[1], 0);
    check_log("wrap");

    // Frame restart mid-burst at address 64.
    for (int k = 0; k < 20 && m_wr != 22'd64; k++) begin
      one_write();
      check_log("rs_pre");
    end
    one_read();
    check_log("rs_rd_pre");
    rd_before = m_rd;
    wr_level = 8'd8;
    wait_cmd(2'd1, "rs_start");
    wr_level = 8'd0;
    repeat (3) tick();
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;
    wait_cmd(2'd0, "rs_end");
    tick();
    one_write();
    one_read();
    chk("rs_burst_addr", q_addr[0], 64);
    chk("rs_burst_beats", q_beats[0], 8);
    chk("rs_next_addr", q_addr[1], 0);
    chk("rs_rd_addr", q_addr[2], rd_before);
    m_wr = 22'd8;
    m_rd = adv(rd_before);
    clear_log();

    // Restart on the final beat of a write burst.
    wr_level = 8'd8;
    wait_cmd(2'd1, "rs_last_start");
    wr_level = 8'd0;
    repeat (7) tick();
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;
    wait_cmd(2'd0, "rs_last_end");
    tick();
    one_write();
    chk("rs_last_burst_addr", q_addr[0], 8);
    chk("rs_last_next_addr", q_addr[1], 0);
    m_wr = 22'd8;
    clear_log();

    // Restart while idle.
    frame_restart = 1'b1;
    tick();
    frame_restart = 1'b0;
    tick();
    one_write();
    chk("rs_idle_addr", q_addr[0], 0);
    m_wr = 22'd8;
    clear_log();

    // Reset at beat 5 of a read burst.
    rd_level = 8'd0;
    wait_cmd(2'd2, "rst_mid_start");
    rd_level = 8'd255;
    repeat (5) tick();
    sdram_rst_n = 1'b0;
    #1;
    chk("rst_mid_command", bus.command, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_address", bus.data_address, 0);
    chk("rst_mid_rd_push", rd_push, 0);
    repeat (2) tick();
    sdram_rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_rd_push", rd_push, 0);
    chk("post_rst_command", bus.command, 0);
    clear_log();
    m_wr = '0;
    m_rd = '0;
    one_write();
    one_read();
    check_log("post_rst");

    chk("stray_strobes", stray, 0);
    chk("addr_unstable", addr_bad, 0);
    chk("busy_mismatch", busy_bad, 0);
    chk("direct_transition", trans_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
